// File: rtl/acc_cpu_pkg.sv
// Shared types for the accumulator CPU: opcode encoding, FSM states, opcode width.
// The optional CALL/RET link register is enabled by defining ACC_CPU_CALL_EN.
package acc_cpu_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_NOP  = 4'h0,
      OP_NOT  = 4'h1,
      OP_LDI  = 4'h2,
      OP_ADD  = 4'h3,
      OP_SUB  = 4'h4,
      OP_XOR  = 4'h5,
      OP_AND  = 4'h6,
      OP_JMP  = 4'h7,
      OP_JZ   = 4'h8,
      OP_JC   = 4'h9,
      OP_CALL = 4'hA,
      OP_RET  = 4'hB,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_e;

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational accumulator ALU: computes the next accumulator and carry for one opcode.
// Jump, CALL/RET, HALT and unassigned opcodes leave the accumulator and carry untouched.
module acc_cpu_alu
   import acc_cpu_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  opcode_e           op,
   input  logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] acc_next,
   output logic              carry_next,
   output logic              carry_we
);

   // Bit DATA_W of the widened result is the carry (ADD) or borrow (SUB).
   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   assign sum  = {1'b0, acc} + {1'b0, imm};
   assign diff = {1'b0, acc} - {1'b0, imm};

   always_comb begin
      acc_next   = acc;
      carry_next = 1'b0;
      carry_we   = 1'b0;
      case (op)
         OP_NOT: acc_next = ~acc;
         OP_LDI: acc_next = imm;
         OP_ADD: begin
            acc_next   = sum[DATA_W-1:0];
            carry_next = sum[DATA_W];
            carry_we   = 1'b1;
         end
         OP_SUB: begin
            acc_next   = diff[DATA_W-1:0];
            carry_next = diff[DATA_W];
            carry_we   = 1'b1;
         end
         OP_XOR:  acc_next = acc ^ imm;
         OP_AND:  acc_next = acc & imm;
         default: ;
      endcase
   end

endmodule

// File: rtl/acc_cpu.sv
// Accumulator CPU top: fetch/ip sequencing, RUN/HALT FSM and architectural registers.
// Define ACC_CPU_CALL_EN to add a one-entry link register for CALL/RET.
module acc_cpu
   import acc_cpu_pkg::*;
#(
   parameter  int DATA_W  = 4,
   parameter  int ADDR_W  = 4,
   localparam int INSTR_W = OP_W + DATA_W
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic [ADDR_W-1:0]  addr,
   output logic [DATA_W-1:0]  led,
   output logic               carry,
   output logic               halted
);

   // instr_valid is a valid-only handshake with no ready: the ROM word is consumed on
   // every rising edge where instr_valid=1 and the core is in RUN; otherwise it is ignored.
   state_e            state, state_next;
   opcode_e           op;
   logic [DATA_W-1:0] acc, imm, alu_acc;
   logic [ADDR_W-1:0] ip, ip_next, ip_inc, tgt;
   logic              alu_carry, alu_carry_we, exec;

   assign op     = opcode_e'(instr[INSTR_W-1 -: OP_W]);
   assign imm    = instr[DATA_W-1:0];
   assign tgt    = imm[ADDR_W-1:0];
   assign ip_inc = ip + ADDR_W'(1);
   assign exec   = (state == RUN) && instr_valid;

   acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .op         (op),
      .acc        (acc),
      .imm        (imm),
      .acc_next   (alu_acc),
      .carry_next (alu_carry),
      .carry_we   (alu_carry_we)
   );

`ifdef ACC_CPU_CALL_EN
   logic [ADDR_W-1:0] link;

   // Single entry: a nested CALL simply overwrites the return address.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                     link <= '0;
      else if (exec && op == OP_CALL) link <= ip_inc;
   end
`endif

   // Branch conditions look at the accumulator/carry before this instruction retires.
   always_comb begin
      ip_next = ip_inc;
      case (op)
         OP_JMP: ip_next = tgt;
         OP_JZ:  if (acc == '0) ip_next = tgt;
         OP_JC:  if (carry) ip_next = tgt;
`ifdef ACC_CPU_CALL_EN
         OP_CALL: ip_next = tgt;
         OP_RET:  ip_next = link;
`endif
         OP_HALT: ip_next = ip;
         default: ;
      endcase
   end

   always_comb begin
      state_next = state;
      if (exec && op == OP_HALT) state_next = HALT;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= RUN;
      else        state <= state_next;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ip    <= '0;
         acc   <= '0;
         carry <= 1'b0;
      end else if (exec) begin
         ip  <= ip_next;
         acc <= alu_acc;
         if (alu_carry_we) carry <= alu_carry;
      end
   end

   // halted is the externally visible view of the FSM state register.
   assign addr   = ip;
   assign led    = acc;
   assign halted = (state == HALT);

endmodule

// File: tb/tb_acc_cpu.sv
// Directed bench for acc_cpu with a combinational ROM model (instr = rom[addr]).
// Build with +define+ACC_CPU_CALL_EN to check the CALL/RET link register.
module tb_acc_cpu;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b1;
   logic [7:0] instr;
   logic       instr_valid = 1'b1;
   logic [3:0] addr;
   logic [3:0] led;
   logic       carry;
   logic       halted;

   logic [7:0] rom [16];
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 CLK = ~CLK;

   assign instr = rom[addr];

   acc_cpu #(.DATA_W(4), .ADDR_W(4)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .instr       (instr),
      .instr_valid (instr_valid),
      .addr        (addr),
      .led         (led),
      .carry       (carry),
      .halted      (halted)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_rom();
      foreach (rom[i]) rom[i] = 8'h00;
   endtask

   // Release reset on a falling edge so the next rising edge executes rom[0].
   task automatic apply_reset();
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      clear_rom();

      // Reset state
      #1 RST_N = 1'b0;
      #1;
      check("rst_addr", 8'(addr), 8'h0);
      check("rst_led", 8'(led), 8'h0);
      check("rst_carry", 8'(carry), 8'h0);
      check("rst_halted", 8'(halted), 8'h0);

      // ALU sequence: LDI 5; ADD 3; ADD 9; SUB 2
      rom[0] = 8'h25; rom[1] = 8'h33; rom[2] = 8'h39; rom[3] = 8'h42;
      apply_reset();
      run(1);
      check("ldi5_led", 8'(led), 8'h5);
      check("ldi5_addr", 8'(addr), 8'h1);
      run(1);
      check("add3_led", 8'(led), 8'h8);
      check("add3_carry", 8'(carry), 8'h0);
      run(1);
      check("add9_led", 8'(led), 8'h1);
      check("add9_carry", 8'(carry), 8'h1);
      run(1);
      check("sub2_led", 8'(led), 8'hF);
      check("sub2_borrow", 8'(carry), 8'h1);
      check("sub2_addr", 8'(addr), 8'h4);

      // Asynchronous reset between edges clears outputs without a clock edge
      #3 RST_N = 1'b0;
      #1;
      check("async_addr", 8'(addr), 8'h0);
      check("async_led", 8'(led), 8'h0);
      check("async_carry", 8'(carry), 8'h0);
      check("async_halted", 8'(halted), 8'h0);

      // Branches: LDI 1; JZ 8 (not taken); ADD F (carry); JC A; at A JMP F; at F JMP 0
      clear_rom();
      rom[0] = 8'h21; rom[1] = 8'h88; rom[2] = 8'h3F; rom[3] = 8'h9A;
      rom[10] = 8'h7F; rom[15] = 8'h70;
      apply_reset();
      run(1);
      check("br_ldi1_led", 8'(led), 8'h1);
      run(1);
      check("jz_not_taken", 8'(addr), 8'h2);
      run(1);
      check("addf_led", 8'(led), 8'h0);
      check("addf_carry", 8'(carry), 8'h1);
      run(1);
      check("jc_taken", 8'(addr), 8'hA);
      run(1);
      check("jmp_to_f", 8'(addr), 8'hF);
      run(1);
      check("jmp0_from_f", 8'(addr), 8'h0);
      check("jmp_keeps_carry", 8'(carry), 8'h1);

      // Stall: LDI 7; ADD A; NOP; then hold at addr 3 with instr_valid low
      clear_rom();
      rom[0] = 8'h27; rom[1] = 8'h3A; rom[3] = 8'h31;
      apply_reset();
      run(3);
      check("pre_stall_addr", 8'(addr), 8'h3);
      check("pre_stall_led", 8'(led), 8'h1);
      check("pre_stall_carry", 8'(carry), 8'h1);
      instr_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         run(1);
         check("stall_addr", 8'(addr), 8'h3);
         check("stall_led", 8'(led), 8'h1);
         check("stall_carry", 8'(carry), 8'h1);
      end
      instr_valid = 1'b1;
      run(1);
      check("resume_addr", 8'(addr), 8'h4);
      check("resume_led", 8'(led), 8'h2);
      check("resume_carry", 8'(carry), 8'h0);

      // Wrap through all NOPs, then HALT at 6
      clear_rom();
      apply_reset();
      run(15);
      check("wrap_addr_f", 8'(addr), 8'hF);
      run(1);
      check("wrap_addr_0", 8'(addr), 8'h0);
      rom[6] = 8'hF0; rom[7] = 8'h23;
      run(6);
      check("pre_halt_addr", 8'(addr), 8'h6);
      check("pre_halt_flag", 8'(halted), 8'h0);
      run(1);
      check("halt_addr", 8'(addr), 8'h6);
      check("halt_flag", 8'(halted), 8'h1);
      rom[6] = 8'h29;
      run(3);
      check("halted_addr_hold", 8'(addr), 8'h6);
      check("halted_led_hold", 8'(led), 8'h0);
      check("halted_flag_hold", 8'(halted), 8'h1);

      // CALL 9 at 2, RET at 9
      clear_rom();
      rom[2] = 8'hA9; rom[9] = 8'hB0;
      apply_reset();
      run(3);
`ifdef ACC_CPU_CALL_EN
      check("call_addr", 8'(addr), 8'h9);
      run(1);
      check("ret_addr", 8'(addr), 8'h3);
`else
      check("call_as_nop", 8'(addr), 8'h3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
